alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 clock  in  1  single system clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 run  in  1  1 = fetch next instruction when in FETCH; 0 = hold in FETCH.
REQ-004 code_addr  out  16  code memory byte address (= pc during fetch).
REQ-005 code_rd  out  1  read request; held until code_valid.
REQ-006 code_data  in  8  code byte, qualified by code_valid.
REQ-007 code_valid  in  1  read acknowledge; sampled only while code_rd=1.
REQ-008 rf_addr  out  3  register-bank index Rn.
REQ-009 rf_rdata  in  8  Rn contents, valid the cycle after rf_addr is presented.
REQ-010 rf_we / rf_wdata  out  1 / 8  one-cycle register write strobe and data.
REQ-011 alu_opcode, alu_op1, alu_op2  out  8 each  opcode (IR) and operands to the ALU.
REQ-012 alu_en  out  1  one-cycle execute strobe.
REQ-013 alu_result  in  9  ALU result, registered by the ALU on the edge where alu_en=1.
REQ-014 alu_c, alu_ac, alu_ov  in  1 each  ALU flags, same timing as alu_result.
REQ-015 acc  out  8  accumulator; psw  out  8  {C,AC,0,0,0,OV,0,P}.
REQ-016 pc  out  16  program counter; illegal  out  1  one-cycle pulse on unsupported opcode.

Function
REQ-017 Supported opcodes: NOP 00; MOV A,#d 74; MOV A,Rn E8-EF; MOV Rn,#d 78-7F; ADD 24/28-2F; SUBB 94/98-9F; ANL 54/58-5F; ORL 44/48-4F; XRL 64/68-6F (#d form / Rn form).
REQ-018 States: FETCH, FETCH_IMM, READ_RF, EXEC, WB.
REQ-019 FETCH: if run=1, code_rd=1 with code_addr=pc; on code_valid latch IR=code_data and pc+=1; NOP returns to FETCH, illegal pulses illegal=1 and returns to FETCH, #d forms go to FETCH_IMM, Rn forms to READ_RF.
REQ-020 FETCH_IMM: code_rd=1 at pc; on code_valid latch operand=code_data, pc+=1, go EXEC.
REQ-021 READ_RF: rf_addr=IR[2:0] for one cycle; latch operand=rf_rdata next cycle, go EXEC (READ_RF lasts 2 cycles).
REQ-022 EXEC: alu_en=1 one cycle, alu_opcode=IR, alu_op1=acc, alu_op2=operand; go WB.
REQ-023 WB: MOV Rn,#d -> rf_we=1, rf_addr=IR[2:0], rf_wdata=alu_result[7:0]; all other supported ops -> acc=alu_result[7:0]; go FETCH.
REQ-024 WB for ADD/SUBB only: psw[7]=alu_c, psw[6]=alu_ac, psw[2]=alu_ov; other ops leave C/AC/OV unchanged.
REQ-025 psw[0] (P) = XOR-reduction of acc, updated every cycle; other psw bits constant 0.
REQ-026 pc wraps FFFF -> 0000 with no flag.
REQ-027 code_rd, rf_we, alu_en, illegal are 0 in every state not listed as driving them.
REQ-028 run deasserted mid-instruction has no effect until return to FETCH.
REQ-029 code_valid arriving while code_rd=0 is ignored.

Reset
REQ-030 reset=1 at any edge, including mid-instruction: state=FETCH, pc=0000, acc=00, psw=00, IR=00, all strobes 0; pending memory read abandoned; no rf or acc write of the interrupted instruction.
REQ-031 First fetch after reset occurs on the first cycle with reset=0 and run=1.

Verification
REQ-032 Code 74 35 24 CB, zero-wait memory: acc=35 then acc=00, psw C=1, pc=0004.
REQ-033 R3=0F, code 74 F0 5B: ANL gives acc=00, psw P=0, C/AC/OV unchanged from prior values.
REQ-034 Code 7D 5A then ED: rf_we pulse with rf_addr=5, rf_wdata=5A; then acc=5A, P=0.
REQ-035 Code A5 then 00: illegal pulses once, acc/psw unchanged, pc=0002.
REQ-036 code_valid delayed 3 cycles on each read: code_rd held throughout, result identical to zero-wait run.
REQ-037 Assert reset during EXEC of ADD A,#10 from acc=F0: acc=00, psw=00, pc=0000, no WB write occurs.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer for a small 8051-style ALU subset.
// Fetches opcode/immediate bytes, reads Rn, strobes an external ALU and writes back.
module alu_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    output logic [15:0] code_addr,
    output logic        code_rd,
    input  logic [7:0]  code_data,
    input  logic        code_valid,
    output logic [2:0]  rf_addr,
    input  logic [7:0]  rf_rdata,
    output logic        rf_we,
    output logic [7:0]  rf_wdata,
    output logic [7:0]  alu_opcode,
    output logic [7:0]  alu_op1,
    output logic [7:0]  alu_op2,
    output logic        alu_en,
    input  logic [8:0]  alu_result,
    input  logic        alu_c,
    input  logic        alu_ac,
    input  logic        alu_ov,
    output logic [7:0]  acc,
    output logic [7:0]  psw,
    output logic [15:0] pc,
    output logic        illegal
);

    typedef enum logic [2:0] {
        StFetch,
        StFetchImm,
        StReadRf,
        StExec,
        StWb
    } state_e;

    typedef enum logic [1:0] {
        OpNop,
        OpImm,
        OpRn,
        OpBad
    } op_class_e;

    function automatic op_class_e decode(input logic [7:0] op);
        op_class_e cls;
        cls = OpBad;
        if (op == 8'h00) begin
            cls = OpNop;
        end else if (op == 8'h74 || op[7:3] == 5'b01111) begin
            cls = OpImm;
        end else if (op[7:3] == 5'b11101) begin
            cls = OpRn;
        end else if (op[7:4] == 4'h2 || op[7:4] == 4'h9 || op[7:4] == 4'h5 ||
                     op[7:4] == 4'h4 || op[7:4] == 4'h6) begin
            if (op[3:0] == 4'h4) begin
                cls = OpImm;
            end else if (op[3]) begin
                cls = OpRn;
            end
        end
        return cls;
    endfunction

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  opnd_q, opnd_d;
    logic        c_q, c_d;
    logic        ac_q, ac_d;
    logic        ov_q, ov_d;
    logic        rf_phase_q, rf_phase_d;

    logic        is_mov_rn_imm;
    logic        is_arith;
    logic        unused_carry_out;

    assign unused_carry_out = alu_result[8];

    assign is_mov_rn_imm = (ir_q[7:3] == 5'b01111);
    assign is_arith      = (ir_q == 8'h24) || (ir_q == 8'h94) ||
                           (ir_q[7:3] == 5'b00101) || (ir_q[7:3] == 5'b10011);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StFetch;
            pc_q       <= 16'h0000;
            acc_q      <= 8'h00;
            ir_q       <= 8'h00;
            opnd_q     <= 8'h00;
            c_q        <= 1'b0;
            ac_q       <= 1'b0;
            ov_q       <= 1'b0;
            rf_phase_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            acc_q      <= acc_d;
            ir_q       <= ir_d;
            opnd_q     <= opnd_d;
            c_q        <= c_d;
            ac_q       <= ac_d;
            ov_q       <= ov_d;
            rf_phase_q <= rf_phase_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        ir_d       = ir_q;
        opnd_d     = opnd_q;
        c_d        = c_q;
        ac_d       = ac_q;
        ov_d       = ov_q;
        rf_phase_d = rf_phase_q;
        code_rd    = 1'b0;
        rf_we      = 1'b0;
        alu_en     = 1'b0;
        illegal    = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (run) begin
                    code_rd = 1'b1;
                    if (code_valid) begin
                        ir_d = code_data;
                        pc_d = pc_q + 16'd1;
                        unique case (decode(code_data))
                            OpNop: state_d = StFetch;
                            OpBad: illegal = 1'b1;
                            OpImm: state_d = StFetchImm;
                            OpRn: begin
                                state_d    = StReadRf;
                                rf_phase_d = 1'b0;
                            end
                        endcase
                    end
                end
            end
            StFetchImm: begin
                code_rd = 1'b1;
                if (code_valid) begin
                    opnd_d  = code_data;
                    pc_d    = pc_q + 16'd1;
                    state_d = StExec;
                end
            end
            StReadRf: begin
                // The register bank answers one cycle after rf_addr is presented.
                rf_phase_d = 1'b1;
                if (rf_phase_q) begin
                    opnd_d     = rf_rdata;
                    rf_phase_d = 1'b0;
                    state_d    = StExec;
                end
            end
            StExec: begin
                alu_en  = 1'b1;
                state_d = StWb;
            end
            StWb: begin
                if (is_mov_rn_imm) begin
                    rf_we = 1'b1;
                end else begin
                    acc_d = alu_result[7:0];
                end
                if (is_arith) begin
                    c_d  = alu_c;
                    ac_d = alu_ac;
                    ov_d = alu_ov;
                end
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Strobes stay quiet during reset so an interrupted instruction has no side effects.
        if (reset) begin
            code_rd = 1'b0;
            rf_we   = 1'b0;
            alu_en  = 1'b0;
            illegal = 1'b0;
        end
    end

    assign code_addr  = pc_q;
    assign rf_addr    = ir_q[2:0];
    assign rf_wdata   = alu_result[7:0];
    assign alu_opcode = ir_q;
    assign alu_op1    = acc_q;
    assign alu_op2    = opnd_q;
    assign acc        = acc_q;
    assign pc         = pc_q;
    assign psw        = {c_q, ac_q, 3'b000, ov_q, 1'b0, ^acc_q};

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: code memory with wait states, register bank
// and ALU models; retire/register-write/illegal events checked against a queue.
module tb_alu_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [15:0] code_addr;
    logic        code_rd;
    logic [7:0]  code_data;
    logic        code_valid;
    logic [2:0]  rf_addr;
    logic [7:0]  rf_rdata;
    logic        rf_we;
    logic [7:0]  rf_wdata;
    logic [7:0]  alu_opcode, alu_op1, alu_op2;
    logic        alu_en;
    logic [8:0]  alu_result;
    logic        alu_c, alu_ac, alu_ov;
    logic [7:0]  acc, psw;
    logic [15:0] pc;
    logic        illegal;

    always #5 clock = ~clock;

    alu_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .code_addr  (code_addr),
        .code_rd    (code_rd),
        .code_data  (code_data),
        .code_valid (code_valid),
        .rf_addr    (rf_addr),
        .rf_rdata   (rf_rdata),
        .rf_we      (rf_we),
        .rf_wdata   (rf_wdata),
        .alu_opcode (alu_opcode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_en     (alu_en),
        .alu_result (alu_result),
        .alu_c      (alu_c),
        .alu_ac     (alu_ac),
        .alu_ov     (alu_ov),
        .acc        (acc),
        .psw        (psw),
        .pc         (pc),
        .illegal    (illegal)
    );

    // Code memory: acknowledges after wait_n cycles of code_rd; spur injects stray acks.
    logic [7:0] mem [0:255];
    int         wait_n = 0;
    int         wcnt = 0;
    logic       spur = 1'b0;

    assign code_data  = mem[code_addr[7:0]];
    assign code_valid = spur | (code_rd & (wcnt >= wait_n));

    always @(posedge clock) begin
        if (code_rd && !code_valid) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    logic [7:0] regs [0:7];
    always @(posedge clock) begin
        rf_rdata <= regs[rf_addr];
        if (rf_we) regs[rf_addr] <= rf_wdata;
    end

    function automatic logic [11:0] alu_f(input logic [7:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        logic [8:0] r;
        logic c, ac, ov;
        c = 1'b0; ac = 1'b0; ov = 1'b0;
        r = {1'b0, b};
        case (op[7:4])
            4'h2: begin
                r  = {1'b0, a} + {1'b0, b};
                c  = r[8];
                ac = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'h0F;
                ov = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'h9: begin
                r  = {1'b0, a} - {1'b0, b};
                c  = r[8];
                ac = a[3:0] < b[3:0];
                ov = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'h5: r = {1'b0, a & b};
            4'h4: r = {1'b0, a | b};
            4'h6: r = {1'b0, a ^ b};
            default: r = {1'b0, b};
        endcase
        return {c, ac, ov, r};
    endfunction

    always @(posedge clock) begin
        if (alu_en) {alu_c, alu_ac, alu_ov, alu_result} <= alu_f(alu_opcode, alu_op1, alu_op2);
    end

    // Scoreboard
    localparam int KRet = 0;
    localparam int KRfw = 1;
    localparam int KIll = 2;

    typedef struct {
        int          kind;
        logic [15:0] pc;
        logic [7:0]  a;
        logic [7:0]  p;
        logic [2:0]  ra;
        logic [7:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired, expected event did not occur (t=%0t)", name, $time);
    endtask

    task automatic push_ret(input logic [15:0] p_pc, input logic [7:0] p_a, input logic [7:0] p_p);
        exp_t e;
        e = '{kind: KRet, pc: p_pc, a: p_a, p: p_p, ra: 3'd0, rd: 8'h00};
        sb.push_back(e);
    endtask

    task automatic push_ill(input logic [15:0] p_pc, input logic [7:0] p_a, input logic [7:0] p_p);
        exp_t e;
        e = '{kind: KIll, pc: p_pc, a: p_a, p: p_p, ra: 3'd0, rd: 8'h00};
        sb.push_back(e);
    endtask

    task automatic push_rfw(input logic [2:0] p_ra, input logic [7:0] p_rd);
        exp_t e;
        e = '{kind: KRfw, pc: 16'h0, a: 8'h00, p: 8'h00, ra: p_ra, rd: p_rd};
        sb.push_back(e);
    endtask

    task automatic pop_exp(input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: got event kind %0d, expected none (t=%0t)",
                     kind, $time);
        end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            ok = (e.kind == kind);
        end
    endtask

    // Monitor: retire is observed two falling edges after the alu_en cycle.
    int   wb_cnt = 0;
    logic rd_prev = 1'b0;
    logic vld_prev = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        bit   ok;
        if (reset) begin
            wb_cnt   = 0;
            rd_prev  = 1'b0;
            vld_prev = 1'b0;
        end else begin
            if (rd_prev && !vld_prev) check("code_rd_held", code_rd, 1);
            if (rf_we) begin
                pop_exp(KRfw, e, ok);
                if (ok) begin
                    check("rf_addr", rf_addr, e.ra);
                    check("rf_wdata", rf_wdata, e.rd);
                end
            end
            if (wb_cnt == 1) begin
                pop_exp(KRet, e, ok);
                if (ok) begin
                    check("ret_acc", acc, e.a);
                    check("ret_psw", psw, e.p);
                    check("ret_pc", pc, e.pc);
                end
            end
            if (illegal) begin
                pop_exp(KIll, e, ok);
                if (ok) begin
                    check("ill_acc", acc, e.a);
                    check("ill_psw", psw, e.p);
                    check("ill_pc", pc, e.pc);
                end
            end
            if (wb_cnt > 0) wb_cnt = wb_cnt - 1;
            if (alu_en) wb_cnt = 2;
            rd_prev  = code_rd;
            vld_prev = code_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic run_until_pc(input logic [15:0] endpc, input int budget);
        int i;
        run = 1'b1;
        i = 0;
        while (i < budget && pc !== endpc) begin
            tick(1);
            i++;
        end
        run = 1'b0;
        if (pc !== endpc) fail_now("run_until_pc");
    endtask

    task automatic load_program();
        logic [7:0] prog [0:19];
        prog = '{8'h74, 8'h35, 8'h24, 8'hCB, 8'h7B, 8'h0F, 8'h74, 8'hF0, 8'h5B, 8'h7D,
                 8'h5A, 8'hED, 8'hA5, 8'h00, 8'h94, 8'h0B, 8'h44, 8'h80, 8'h6B, 8'h9D};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 20; i++) mem[i] = prog[i];
    endtask

    task automatic push_program_expect();
        push_ret(16'h0002, 8'h35, 8'h00);   // MOV A,#35
        push_ret(16'h0004, 8'h00, 8'hC0);   // ADD A,#CB -> carry, half carry
        push_rfw(3'd3, 8'h0F);              // MOV R3,#0F
        push_ret(16'h0006, 8'h00, 8'hC0);
        push_ret(16'h0008, 8'hF0, 8'hC0);   // MOV A,#F0
        push_ret(16'h0009, 8'h00, 8'hC0);   // ANL A,R3 keeps C/AC
        push_rfw(3'd5, 8'h5A);              // MOV R5,#5A
        push_ret(16'h000B, 8'h00, 8'hC0);
        push_ret(16'h000C, 8'h5A, 8'hC0);   // MOV A,R5
        push_ill(16'h000C, 8'h5A, 8'hC0);   // A5 unsupported
        push_ret(16'h0010, 8'h4F, 8'h41);   // SUBB A,#0B
        push_ret(16'h0012, 8'hCF, 8'h40);   // ORL A,#80
        push_ret(16'h0013, 8'hC0, 8'h40);   // XRL A,R3
        push_ret(16'h0014, 8'h66, 8'h44);   // SUBB A,R5 -> overflow
    endtask

    task automatic run_program(input int waits);
        do_reset();
        wait_n = waits;
        push_program_expect();
        run_until_pc(16'h0014, 400);
        tick(10);
        check("end_pc", pc, 16'h0014);
        check("end_acc", acc, 8'h66);
        check("end_psw", psw, 8'h44);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int i;
        load_program();
        do_reset();

        check("rst_pc", pc, 16'h0000);
        check("rst_acc", acc, 8'h00);
        check("rst_psw", psw, 8'h00);
        check("rst_code_rd", code_rd, 0);
        check("rst_alu_en", alu_en, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_illegal", illegal, 0);

        // Stray acknowledges with run low must not advance anything.
        spur = 1'b1;
        tick(3);
        spur = 1'b0;
        check("spur_pc", pc, 16'h0000);
        check("spur_code_rd", code_rd, 0);

        run = 1'b1;
        #1;
        check("first_fetch_rd", code_rd, 1);
        check("first_fetch_addr", code_addr, 16'h0000);
        run = 1'b0;
        tick(1);

        run_program(0);
        run_program(3);

        // Reset during EXEC of ADD A,#10 with acc=F0.
        do_reset();
        wait_n = 0;
        mem[0] = 8'h74; mem[1] = 8'hF0; mem[2] = 8'h24; mem[3] = 8'h10;
        push_ret(16'h0002, 8'hF0, 8'h00);
        run = 1'b1;
        i = 0;
        while (i < 50 && !(alu_en === 1'b1 && alu_opcode === 8'h24)) begin
            tick(1);
            i++;
        end
        if (!(alu_en === 1'b1 && alu_opcode === 8'h24)) fail_now("wait_add_exec");
        reset = 1'b1;
        run   = 1'b0;
        #1;
        check("rst_exec_alu_en", alu_en, 0);
        tick(2);
        reset = 1'b0;
        check("rst_exec_acc", acc, 8'h00);
        check("rst_exec_psw", psw, 8'h00);
        check("rst_exec_pc", pc, 16'h0000);
        tick(6);
        check("rst_exec_acc_late", acc, 8'h00);
        check("rst_exec_sb", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
